// File: rtl/ifetch.sv
// ifetch: instruction fetch unit. Issues in-order reads to instruction memory,
// buffers returned words with their addresses for decode, and throws away
// responses that belong to fetches made before a branch/jump redirect.
module ifetch #(
    parameter int unsigned N     = 32,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] pc,
    output logic         pc_en,
    input  logic         redirect,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [W-1:0] imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [W-1:0] inst_data,
    output logic [N-1:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] outst;
    logic [CW-1:0] count;
    logic [CW-1:0] discard;

    // Addresses of requests in flight, oldest at aq_rd.
    logic [N-1:0]  aq_addr [DEPTH];
    logic [PW-1:0] aq_rd;
    logic [PW-1:0] aq_wr;

    // Fetched {addr, data} waiting for decode, head at rd_ptr.
    logic [N-1:0]  fb_addr [DEPTH];
    logic [W-1:0]  fb_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic          credit_ok;
    logic          fire;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic [CW-1:0] survivors;

    // Handshake decode: request credit, response acceptance, decode pop.
    always_comb begin
        credit_ok      = ({1'b0, outst} + {1'b0, count}) < (CW+1)'(DEPTH);
        imem_req_valid = !reset && (state == RUN) && !redirect && credit_ok;
        fire           = imem_req_valid && imem_req_ready;
        pc_en          = fire;
        imem_req_addr  = pc;
        // A response with nothing outstanding is a protocol violation and is ignored.
        rsp_ok         = imem_rsp_valid &&
                         ((state == RUN) ? (outst != '0) : (discard != '0));
        push           = (state == RUN) && !redirect && rsp_ok;
        inst_valid     = (count != '0) && !redirect;
        pop            = inst_valid && inst_ready;
        inst_data      = fb_data[rd_ptr];
        inst_pc        = fb_addr[rd_ptr];
        // Stale fetches still owed by memory after a redirect this cycle.
        survivors      = outst - CW'(rsp_ok);
    end

    // Fetch FSM with request tracking and instruction buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            outst   <= '0;
            count   <= '0;
            discard <= '0;
            aq_rd   <= '0;
            aq_wr   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                aq_addr[i] <= '0;
                fb_addr[i] <= '0;
                fb_data[i] <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        outst  <= '0;
                        count  <= '0;
                        aq_rd  <= '0;
                        aq_wr  <= '0;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        if (survivors != '0) begin
                            discard <= survivors;
                            state   <= DRAIN;
                        end
                    end else begin
                        if (fire) begin
                            aq_addr[aq_wr] <= pc;
                            aq_wr          <= aq_wr + PW'(1);
                        end
                        if (push) begin
                            fb_addr[wr_ptr] <= aq_addr[aq_rd];
                            fb_data[wr_ptr] <= imem_rsp_data;
                            wr_ptr          <= wr_ptr + PW'(1);
                            aq_rd           <= aq_rd + PW'(1);
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end
                        outst <= outst + CW'(fire) - CW'(push);
                        count <= count + CW'(push) - CW'(pop);
                    end
                end
                DRAIN: begin
                    // Buffer is already empty; a further redirect adds nothing to drain.
                    if (rsp_ok) begin
                        discard <= discard - CW'(1);
                        if (discard == CW'(1)) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized bench for ifetch with an in-order memory model and a
// queue-based reference of what fetch and decode should observe each cycle.
module tb_ifetch;

    localparam int unsigned N     = 32;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;

    logic         clock;
    logic         reset;
    logic [N-1:0] pc;
    logic         pc_en;
    logic         redirect;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [N-1:0] imem_req_addr;
    logic         imem_rsp_valid;
    logic [W-1:0] imem_rsp_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [W-1:0] inst_data;
    logic [N-1:0] inst_pc;

    ifetch #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .pc_en          (pc_en),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] addr;
        int unsigned  due;
    } mreq_t;

    // Memory: requests in flight with the cycle their response is due.
    mreq_t        mem_q[$];
    // Reference: addresses of instructions waiting for decode, oldest first.
    logic [N-1:0] buf_q[$];
    int           m_outst;
    int           m_disc;
    bit           m_drain;

    logic [N-1:0] next_pc;
    int unsigned  cyc;
    int unsigned  last_due;
    int unsigned  p_mready, p_iready, p_redir, p_spur, lat_min, lat_max;
    int           force_redir;
    logic [N-1:0] force_tgt;
    int           first_iv;
    int           n_fire;
    int           post_fire_cyc;
    logic [N-1:0] post_fire_addr;
    bit           redir_seen;
    int           n_tests;
    int           n_fail;

    function automatic logic [W-1:0] memf(input logic [N-1:0] a);
        return W'(a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_knobs(input int unsigned mr, input int unsigned ir, input int unsigned rd,
                             input int unsigned sp, input int unsigned lmin, input int unsigned lmax);
        p_mready = mr;
        p_iready = ir;
        p_redir  = rd;
        p_spur   = sp;
        lat_min  = lmin;
        lat_max  = lmax;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rst imem_req_valid", 64'(imem_req_valid), 64'(0));
        check("rst pc_en", 64'(pc_en), 64'(0));
        check("rst inst_valid", 64'(inst_valid), 64'(0));
        check("rst inst_data", 64'(inst_data), 64'(0));
        check("rst inst_pc", 64'(inst_pc), 64'(0));
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        pc             = '0;
        next_pc        = '0;
        mem_q.delete();
        buf_q.delete();
        m_outst        = 0;
        m_disc         = 0;
        m_drain        = 1'b0;
        cyc            = 0;
        last_due       = 0;
        first_iv       = -1;
        n_fire         = 0;
        post_fire_cyc  = -1;
        post_fire_addr = '0;
        redir_seen     = 1'b0;
        force_redir    = -1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bit           redir, rsp_real, exp_rv, exp_iv, fire, pop;
            logic [N-1:0] rsp_addr, tgt;
            int unsigned  lat, due;
            @(negedge clock);
            pc    = next_pc;
            redir = (force_redir == int'(cyc)) || ($urandom_range(99) < p_redir);
            tgt   = (force_redir == int'(cyc)) ? force_tgt : N'($urandom);
            redirect       = redir;
            imem_req_ready = $urandom_range(99) < p_mready;
            inst_ready     = $urandom_range(99) < p_iready;
            rsp_real = 1'b0;
            rsp_addr = '0;
            if (mem_q.size() > 0) begin
                if (mem_q[0].due <= cyc) begin
                    rsp_real = 1'b1;
                    rsp_addr = mem_q[0].addr;
                end
            end
            if (rsp_real) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(rsp_addr);
            end else if ((mem_q.size() == 0) && ($urandom_range(99) < p_spur)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = W'($urandom);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = W'($urandom);
            end
            #1;
            exp_rv = !m_drain && !redir && ((m_outst + buf_q.size()) < int'(DEPTH));
            exp_iv = (buf_q.size() > 0) && !redir;
            fire   = exp_rv && imem_req_ready;
            pop    = exp_iv && inst_ready;
            check("imem_req_valid", 64'(imem_req_valid), 64'(exp_rv));
            check("pc_en", 64'(pc_en), 64'(fire));
            if (exp_rv) check("imem_req_addr", 64'(imem_req_addr), 64'(pc));
            check("inst_valid", 64'(inst_valid), 64'(exp_iv));
            if (exp_iv) begin
                check("inst_pc", 64'(inst_pc), 64'(buf_q[0]));
                check("inst_data", 64'(inst_data), 64'(memf(buf_q[0])));
                if (first_iv < 0) first_iv = int'(cyc);
            end
            if (redir) redir_seen = 1'b1;
            if (fire && redir_seen && (post_fire_cyc < 0)) begin
                post_fire_cyc  = int'(cyc);
                post_fire_addr = pc;
            end
            @(posedge clock);
            // Memory: retire the response just delivered, accept the new request.
            if (rsp_real) void'(mem_q.pop_front());
            if (fire) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due < last_due) due = last_due;
                last_due = due;
                mem_q.push_back(mreq_t'{addr: pc, due: due});
                n_fire++;
            end
            // Reference behaviour of the fetch unit for this cycle.
            if (m_drain) begin
                if (imem_rsp_valid && (m_disc > 0)) begin
                    m_disc--;
                    if (m_disc == 0) m_drain = 1'b0;
                end
            end else if (redir) begin
                if (imem_rsp_valid && (m_outst > 0)) m_outst--;
                buf_q.delete();
                if (m_outst > 0) begin
                    m_drain = 1'b1;
                    m_disc  = m_outst;
                end
                m_outst = 0;
            end else begin
                if (pop) void'(buf_q.pop_front());
                if (imem_rsp_valid && (m_outst > 0)) begin
                    buf_q.push_back(rsp_addr);
                    m_outst--;
                end
                if (fire) m_outst++;
            end
            next_pc = redir ? tgt : (fire ? pc + N'(1) : pc);
            cyc++;
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        pc             = '0;
        force_redir    = -1;
        force_tgt      = '0;

        // Straight-line fetch, 1-cycle memory, decode always ready.
        set_knobs(100, 100, 0, 0, 1, 1);
        apply_reset();
        run_cycles(12);
        check("first inst_valid cycle", 64'(first_iv), 64'(2));
        check("straight-line requests", 64'(n_fire), 64'(12));

        // Decode backpressure: only DEPTH requests before the credit runs out.
        set_knobs(100, 0, 0, 0, 1, 1);
        apply_reset();
        run_cycles(10);
        check("backpressure requests", 64'(n_fire), 64'(DEPTH));
        p_iready = 100;
        run_cycles(10);

        // Memory stall: nothing accepted, PC held.
        set_knobs(0, 100, 0, 0, 1, 1);
        apply_reset();
        run_cycles(5);
        check("stall requests", 64'(n_fire), 64'(0));
        check("stall held addr", 64'(imem_req_addr), 64'(0));
        p_mready = 100;
        run_cycles(6);

        // Redirect with two stale fetches, 3-cycle memory.
        set_knobs(100, 100, 0, 0, 3, 3);
        apply_reset();
        force_redir = 4;
        force_tgt   = 32'h40;
        run_cycles(12);
        check("drain first req cycle", 64'(post_fire_cyc), 64'(7));
        check("drain first req addr", 64'(post_fire_addr), 64'(32'h40));

        // Redirect with buffered entries but nothing outstanding.
        set_knobs(100, 0, 0, 0, 1, 1);
        apply_reset();
        run_cycles(2);
        p_mready = 0;
        run_cycles(2);
        force_redir = 4;
        force_tgt   = 32'h123;
        p_mready    = 100;
        run_cycles(4);
        check("flush first req cycle", 64'(post_fire_cyc), 64'(5));
        check("flush first req addr", 64'(post_fire_addr), 64'(32'h123));

        // Reset mid-stream with three outstanding and one buffered.
        set_knobs(100, 0, 0, 0, 3, 3);
        apply_reset();
        run_cycles(4);
        #2;
        check("pre-reset inst_valid", 64'(inst_valid), 64'(1));
        apply_reset();
        p_iready = 100;
        run_cycles(10);

        // Randomized traffic: stalls, backpressure, redirects, spurious responses.
        set_knobs(70, 70, 4, 3, 1, 4);
        apply_reset();
        run_cycles(4000);
        set_knobs(90, 90, 10, 5, 1, 3);
        run_cycles(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the RISC-V core. It sits between the program counter and instruction memory. It takes the word address presented by the program counter and issues in-order read requests to instruction memory under a valid/ready handshake. Returned instructions are buffered with their addresses and handed to decode under a second valid/ready handshake. It also gates program-counter advance and discards stale fetches when a branch or jump redirects the PC.

## Interface
- N, 32, address width (word addresses; PC advances by 1 per instruction)
- W, 32, instruction width
- DEPTH, 4, instruction buffer entries; power of 2, minimum 2
- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- pc  in  N  current fetch address from program counter
- pc_en  out  1  program counter may increment this cycle (request accepted)
- redirect  in  1  branch/jump taken this cycle; PC loads its target at this edge
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  N  read address, equal to pc
- imem_rsp_valid  in  1  read data valid; responses return in request order
- imem_rsp_data  in  W  instruction word
- inst_valid  out  1  buffered instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  W  instruction at head of buffer
- inst_pc  out  N  word address of inst_data

## Operation
- Counters:
  - outst (0..DEPTH) counts requests issued but not yet returned.
  - count (0..DEPTH) counts buffer occupancy.
  - Both counters are clog2(DEPTH)+1 bits wide.
- Address queue: DEPTH entries, holding the address of each outstanding request. It is pushed on request fire and popped on response.
- Buffer: circular FIFO of {addr, data}. Read/write pointers wrap modulo DEPTH.
- FSM states: RUN, DRAIN. Reset state is RUN.
- RUN, request issue:
  - imem_req_valid = !redirect && (outst + count < DEPTH).
  - Fire = imem_req_valid && imem_req_ready.
  - pc_en = fire.
- RUN, response handling: each imem_rsp_valid pushes {head of address queue, imem_rsp_data} into the buffer and decrements outst.
- RUN, redirect:
  - Any response in the same cycle is dropped.
  - The buffer is cleared (count = 0, pointers reset).
  - The address queue is cleared.
  - If outst minus that cycle's dropped response is > 0: load discard = that value and go to DRAIN. Otherwise stay in RUN.
- DRAIN:
  - imem_req_valid = 0.
  - Every imem_rsp_valid is dropped and decrements discard.
  - When discard reaches 0, go to RUN at that edge.
  - A redirect in DRAIN leaves discard unchanged and keeps the buffer empty.
- Decode side:
  - inst_valid = (count > 0) && !redirect.
  - Pop on inst_valid && inst_ready.
  - A push and a pop in the same cycle leave count unchanged.
- imem_req_valid may deassert without a handshake only due to redirect or the credit limit.
- imem_rsp_valid with outst = 0 in RUN (or discard = 0 in DRAIN) is a protocol violation. It is ignored and changes no state.

## Timing
- Reset values: imem_req_valid 0, pc_en 0, inst_valid 0, inst_data 0, inst_pc 0, outst 0, count 0, discard 0, state RUN.
- First request: imem_req_valid is 1 in the first cycle after reset deasserts.
- Latency:
  - A response at cycle t appears at inst_valid at t+1 (registered buffer, no bypass).
  - With a 1-cycle memory, request at t gives decode at t+2.
- Throughput: sustained 1 instruction/cycle requires DEPTH >= memory latency + 2. The credit check uses registered outst and count.
- Redirect:
  - The new PC is presented at redirect cycle + 1.
  - The first request for the target is at redirect + 1 if no fetch is outstanding. Otherwise it is at the cycle after the last stale response.
- Reset mid-operation: all state clears immediately. Responses for pre-reset requests are the memory's responsibility to squash.

## Test plan
- Straight-line fetch: 1-cycle memory, pc 0→7 advancing on pc_en, inst_ready = 1. Expect inst_pc 0..7 in order, with inst_data matching memory, first inst_valid at cycle 2, then one per cycle.
- Backpressure: inst_ready = 0 from cycle 0. Expect exactly DEPTH = 4 requests issued, then imem_req_valid low. Raising inst_ready delivers addresses 0..3 in order, and fetching resumes at address 4.
- Memory stall: imem_req_ready low for 5 cycles. Expect pc_en = 0 and pc held throughout, then the request is accepted and inst_pc matches the held pc.
- Redirect with 2 outstanding: 3-cycle memory, redirect at cycle 4 to target 0x40. Expect the buffer flushed, inst_valid = 0 during the redirect cycle, the 2 stale responses dropped, and first request address 0x40 right after the last stale response.
- Redirect, nothing outstanding: buffer holds 2 entries, outst = 0. Expect a flush, state stays RUN, and a request to the target at the next cycle.
- Reset mid-stream: assert reset while outst = 3 and count = 1. Expect all outputs 0 asynchronously, and fetch restarting from pc 0 after deassertion.
